// File: rtl/divider_group10.sv
// divider_group10 - sequential unsigned 16/8 restoring divider, one
// shift-subtract step per clock under a small controller FSM.
//
// Ports:
//   clk    : the only clock, rising edge
//   rst    : synchronous, active-high reset
//   go     : level-sampled start request (a new run needs go low, then high)
//   sw1    : 16-bit dividend, latched when a run starts
//   sw2    : 8-bit divisor, latched when a run starts
//   Q, R   : registered quotient / remainder, updated only on entry to DONE
//   over   : result valid, high while in DONE
//   err    : divide-by-zero or quotient overflow (Q = R = 8'hFF)
//   state  : FSM state code for debug
//
// Build option: define SIGNED_DIV_EN to treat sw1/sw2 as two's complement.
// Division then runs on magnitudes, with a sign fix in FIX, and truncates
// toward zero.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for go, operands latched on the go edge
// LOAD  | operand pre-processing (magnitudes in signed build)
// CHECK | divide-by-zero / overflow test, seed partial remainder
// ITER  | 8 restoring shift-subtract steps
// FIX   | publish quotient and remainder (sign-corrected if signed)
// DONE  | result valid, wait for go low
module divider_group10 (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [15:0] sw1,
   input  logic [7:0]  sw2,
   output logic [7:0]  Q,
   output logic [7:0]  R,
   output logic        over,
   output logic        err,
   output logic [2:0]  state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_ITER  = 3'd3;
   localparam logic [2:0] S_FIX   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [15:0] d;
   logic [7:0]  v;
   logic [8:0]  p;
   logic [7:0]  s;
   logic [3:0]  cnt;

   logic [8:0]  shifted;
   logic [8:0]  trial;
   logic        take;
   logic        ovf;
   logic [7:0]  q_fix;
   logic [7:0]  r_fix;

   // P stays below V throughout the iteration, so a 9-bit compare is an
   // exact stand-in for the sign of the trial subtraction.
   assign shifted = {p[7:0], s[7]};
   assign trial   = shifted - {1'b0, v};
   assign take    = (shifted >= {1'b0, v});

   assign over = (state == S_DONE);

`ifdef SIGNED_DIV_EN
   logic        neg_d;
   logic        neg_v;
   logic [16:0] lim;

   // Quotient magnitude may reach 128 only when the result is negative.
   // d >= 128*v (or 129*v) is the exact test for quotient > 127 (or 128).
   always_comb begin
      lim = {2'b00, v, 7'b0000000};
      if (neg_d ^ neg_v)
         lim = {2'b00, v, 7'b0000000} + {9'b0, v};
      ovf = ({1'b0, d} >= lim);
   end

   assign q_fix = (neg_d ^ neg_v) ? (~s + 8'd1) : s;
   assign r_fix = neg_d ? (~p[7:0] + 8'd1) : p[7:0];
`else
   // Upper dividend byte >= divisor means the quotient needs 9+ bits.
   assign ovf   = (d[15:8] >= v);
   assign q_fix = s;
   assign r_fix = p[7:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         d     <= '0;
         v     <= '0;
         p     <= '0;
         s     <= '0;
         cnt   <= '0;
         Q     <= '0;
         R     <= '0;
         err   <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_d <= 1'b0;
         neg_v <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  d     <= sw1;
                  v     <= sw2;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
`ifdef SIGNED_DIV_EN
               neg_d <= d[15];
               neg_v <= v[7];
               d     <= d[15] ? (~d + 16'd1) : d;
               v     <= v[7] ? (~v + 8'd1) : v;
`endif
               state <= S_CHECK;
            end
            S_CHECK: begin
               if ((v == 8'd0) || ovf) begin
                  Q     <= 8'hFF;
                  R     <= 8'hFF;
                  err   <= 1'b1;
                  state <= S_DONE;
               end else begin
                  p     <= {1'b0, d[15:8]};
                  s     <= d[7:0];
                  cnt   <= 4'd0;
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               p     <= take ? trial : shifted;
               s     <= {s[6:0], take};
               cnt   <= cnt + 4'd1;
               if (cnt == 4'd7)
                  state <= S_FIX;
            end
            S_FIX: begin
               Q     <= q_fix;
               R     <= r_fix;
               err   <= 1'b0;
               state <= S_DONE;
            end
            S_DONE: begin
               if (!go)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_group10.sv
// Self-checking bench for divider_group10: directed scenarios plus a
// randomized sweep compared against an arithmetic reference model.
module tb_divider_group10;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [15:0] sw1;
   logic [7:0]  sw2;
   logic [7:0]  Q;
   logic [7:0]  R;
   logic        over;
   logic        err;
   logic [2:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   divider_group10 dut (
      .clk   (clk),
      .rst   (rst),
      .go    (go),
      .sw1   (sw1),
      .sw2   (sw2),
      .Q     (Q),
      .R     (R),
      .over  (over),
      .err   (err),
      .state (state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer division from the operand values.
   function automatic void model(input logic [15:0] d, input logic [7:0] v,
                                 output logic [7:0] eq, output logic [7:0] er,
                                 output logic ee);
      int q;
      int r;
`ifdef SIGNED_DIV_EN
      int sd;
      int sv;
      sd = $signed(d);
      sv = $signed(v);
      q  = 0;
      r  = 0;
      if (sv != 0) begin
         q = sd / sv;
         r = sd % sv;
      end
      ee = (sv == 0) || (q > 127) || (q < -128);
`else
      q  = 0;
      r  = 0;
      if (v != 0) begin
         q = int'(d) / int'(v);
         r = int'(d) % int'(v);
      end
      ee = (v == 0) || (q > 255);
`endif
      eq = ee ? 8'hFF : q[7:0];
      er = ee ? 8'hFF : r[7:0];
   endfunction

   // One run with a single-cycle go pulse; lat counts edges after E0 until
   // over is seen (bounded). Outputs are captured at over, then DONE->IDLE.
   task automatic run_div(input logic [15:0] d, input logic [7:0] v,
                          input bit scramble, output int lat,
                          output bit saw_iter, output logic [7:0] q_o,
                          output logic [7:0] r_o, output logic e_o);
      sw1 = d;
      sw2 = v;
      go  = 1'b1;
      tick();
      go  = 1'b0;
      if (scramble) begin
         sw1 = 16'($urandom);
         sw2 = 8'($urandom);
      end
      lat      = 0;
      saw_iter = 1'b0;
      while (!over && lat < 20) begin
         tick();
         lat++;
         if (state == 3'd3) saw_iter = 1'b1;
      end
      q_o = Q;
      r_o = R;
      e_o = err;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      go  = 1'b0;
      sw1 = 16'd0;
      sw2 = 8'd0;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (state !== 3'd0 || over !== 1'b0 || err !== 1'b0 || Q !== 8'd0 || R !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d over=%b err=%b Q=%0d R=%0d expected all zero",
                  state, over, err, Q, R);
      end
   endtask

   task automatic test_basic();
      int seq[11] = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4};
      sw1 = 16'd100;
      sw2 = 8'd7;
      go  = 1'b1;
      tick();
      go  = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (state !== 3'(seq[i]) || over !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_trace[%0d]: state=%0d over=%b expected state=%0d over=0",
                     i, state, over, seq[i]);
         end
      end
      tick();
      n_checks++;
      if (state !== 3'd5 || over !== 1'b1 || Q !== 8'd14 || R !== 8'd2 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: state=%0d over=%b Q=%0d R=%0d err=%b expected 5 1 14 2 0",
                  state, over, Q, R, err);
      end
      tick();
      n_checks++;
      if (state !== 3'd0 || over !== 1'b0 || Q !== 8'd14 || R !== 8'd2) begin
         n_fail++;
         $display("FAIL basic_hold: state=%0d over=%b Q=%0d R=%0d expected 0 0 14 2",
                  state, over, Q, R);
      end
   endtask

   task automatic check_run(input string name, input logic [15:0] d,
                            input logic [7:0] v, input bit scramble);
      logic [7:0] eq, er, q_o, r_o;
      logic       ee, e_o;
      int         lat;
      bit         saw;
      model(d, v, eq, er, ee);
      run_div(d, v, scramble, lat, saw, q_o, r_o, e_o);
      n_checks++;
      if (q_o !== eq || r_o !== er || e_o !== ee || lat != (ee ? 2 : 11)) begin
         n_fail++;
         $display("FAIL %s: d=%h v=%h got Q=%h R=%h err=%b lat=%0d expected Q=%h R=%h err=%b lat=%0d",
                  name, d, v, q_o, r_o, e_o, lat, eq, er, ee, ee ? 2 : 11);
      end
      if (ee) begin
         n_checks++;
         if (saw) begin
            n_fail++;
            $display("FAIL %s_no_iter: ITER visited=1 expected 0", name);
         end
      end
   endtask

   task automatic test_boundaries();
      check_run("full_range", 16'h00FF, 8'd1, 1'b0);
      check_run("overflow",   16'h0100, 8'd1, 1'b0);
      check_run("div_zero",   16'h1234, 8'd0, 1'b0);
      check_run("max_ok",     16'hFEFF, 8'hFF, 1'b0);
   endtask

   task automatic test_go_held();
      int lat;
      sw1 = 16'd50;
      sw2 = 8'd5;
      go  = 1'b1;
      tick();
      lat = 0;
      while (!over && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat != 11 || Q !== 8'd10 || R !== 8'd0) begin
         n_fail++;
         $display("FAIL go_held_run: lat=%0d Q=%0d R=%0d expected 11 10 0", lat, Q, R);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (state !== 3'd5 || over !== 1'b1) begin
            n_fail++;
            $display("FAIL go_held_stay[%0d]: state=%0d over=%b expected 5 1", i, state, over);
         end
      end
      go = 1'b0;
      tick();
      tick();
      n_checks++;
      if (state !== 3'd0 || over !== 1'b0 || Q !== 8'd10) begin
         n_fail++;
         $display("FAIL go_held_release: state=%0d over=%b Q=%0d expected 0 0 10", state, over, Q);
      end
   endtask

   task automatic test_reset_mid_iter();
      sw1 = 16'd1000;
      sw2 = 8'd9;
      go  = 1'b1;
      tick();
      go  = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++;
         $display("FAIL mid_iter_pre: state=%0d expected 3", state);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (state !== 3'd0 || Q !== 8'd0 || R !== 8'd0 || over !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_iter_reset: state=%0d Q=%0d R=%0d over=%b err=%b expected all zero",
                  state, Q, R, over, err);
      end
      check_run("after_reset", 16'd1000, 8'd9, 1'b1);
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed();
      logic [7:0] q_o, r_o;
      logic       e_o;
      int         lat;
      bit         saw;
      run_div(16'hFF9C, 8'd7, 1'b0, lat, saw, q_o, r_o, e_o);
      n_checks++;
      if (q_o !== 8'hF2 || r_o !== 8'hFE || e_o !== 1'b0 || lat != 11) begin
         n_fail++;
         $display("FAIL signed_m100_7: Q=%h R=%h err=%b lat=%0d expected F2 FE 0 11",
                  q_o, r_o, e_o, lat);
      end
      run_div(16'hFC00, 8'd8, 1'b0, lat, saw, q_o, r_o, e_o);
      n_checks++;
      if (q_o !== 8'h80 || r_o !== 8'h00 || e_o !== 1'b0) begin
         n_fail++;
         $display("FAIL signed_m1024_8: Q=%h R=%h err=%b expected 80 00 0", q_o, r_o, e_o);
      end
      check_run("signed_pos_ovf", 16'd1024, 8'd8, 1'b0);
   endtask
`endif

   task automatic test_random();
      logic [15:0] d;
      logic [7:0]  v;
      int          vi;
      for (int i = 0; i < 60; i++) begin
         v  = 8'($urandom);
         vi = int'(v);
`ifdef SIGNED_DIV_EN
         d = 16'($urandom);
`else
         if (vi == 0 || $urandom_range(0, 3) == 0)
            d = 16'($urandom);
         else
            d = 16'($urandom_range(0, vi * 256 - 1));
`endif
         check_run("random", d, v, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_go_held();
      test_reset_mid_iter();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
